readout_framer: RTL and testbench

READOUT_FRAMER -- requirements
Module: readout_framer

---
 rtl/readout_framer.sv | 146 ++++++++++++++
 tb/tb_readout_framer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_framer.sv
// Readout framer: picks raw, filtered, lock-in or an internal ramp as the sample source and
// captures all channels coherently, tagged with a frame counter, into a freezable output register.
module readout_framer #(
  parameter int NCH    = 2,
  parameter int DW     = 24,
  parameter int CW     = 8,
  parameter int TP_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode_i,
  input  logic [NCH*DW-1:0]     raw_data_i,
  input  logic                  raw_tick_i,
  input  logic [NCH*DW-1:0]     filt_data_i,
  input  logic                  filt_tick_i,
  input  logic [NCH*DW-1:0]     li_data_i,
  input  logic                  li_tick_i,
  input  logic                  freeze_i,
  input  logic                  clear_i,
  output logic [NCH*(CW+DW)-1:0] oreg_o,
  output logic                  valid_o,
  output logic [15:0]           dropped_o,
  output logic [3:0]            led_o
);

  localparam int FW   = CW + DW;
  localparam int DIVW = $clog2(TP_DIV);

  logic [1:0]          mode_q;
  logic [DIVW-1:0]     div_q, div_d;
  logic [DW-1:0]       ramp_q, ramp_d;
  logic [CW-1:0]       fc_q, fc_d;
  logic [NCH*FW-1:0]   oreg_q, oreg_d;
  logic                valid_q, valid_d;
  logic [15:0]         dropped_q, dropped_d;
  logic [3:0]          led_q, led_d;

  logic                switch_s, tp_tick_s, sel_tick_s, act_tick_s, cap_s, drop_s;
  logic [NCH*DW-1:0]   sel_data_s, tp_data_s;

  assign switch_s  = (mode_i != mode_q);
  assign tp_tick_s = (mode_q == 2'd3) && (div_q == DIVW'(TP_DIV - 1));

  // Test-pattern channels are built from the ramp value this tick will store.
  always_comb begin
    tp_data_s = '0;
    for (int k = 0; k < NCH; k++) begin
      tp_data_s[k*DW +: DW] = ramp_q + DW'(k + 1);
    end
  end

  // Source multiplexer driven by the registered mode.
  always_comb begin
    sel_tick_s = 1'b0;
    sel_data_s = '0;
    case (mode_q)
      2'd0: begin sel_tick_s = raw_tick_i;  sel_data_s = raw_data_i;  end
      2'd1: begin sel_tick_s = filt_tick_i; sel_data_s = filt_data_i; end
      2'd2: begin sel_tick_s = li_tick_i;   sel_data_s = li_data_i;   end
      2'd3: begin sel_tick_s = tp_tick_s;   sel_data_s = tp_data_s;   end
      default: begin sel_tick_s = 1'b0;     sel_data_s = '0;          end
    endcase
  end

  // A tick landing on a mode switch is discarded outright.
  assign act_tick_s = sel_tick_s & ~switch_s;
  assign cap_s      = act_tick_s & ~freeze_i;
  assign drop_s     = act_tick_s & freeze_i;

  // Next-state logic for counters, capture register and status.
  always_comb begin
    fc_d      = fc_q;
    div_d     = div_q;
    ramp_d    = ramp_q;
    oreg_d    = oreg_q;
    dropped_d = dropped_q;

    if (switch_s) begin
      fc_d = '0;
    end else if (act_tick_s) begin
      fc_d = fc_q + CW'(1);
    end else begin
      fc_d = fc_q;
    end

    if (switch_s || (mode_q != 2'd3) || tp_tick_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIVW'(1);
    end

    if (act_tick_s && (mode_q == 2'd3)) begin
      ramp_d = ramp_q + DW'(1);
    end else begin
      ramp_d = ramp_q;
    end

    if (cap_s) begin
      for (int k = 0; k < NCH; k++) begin
        oreg_d[k*FW +: FW] = {fc_q + CW'(1), sel_data_s[k*DW +: DW]};
      end
    end else begin
      oreg_d = oreg_q;
    end

    if (clear_i) begin
      dropped_d = {15'd0, drop_s};
    end else if (drop_s && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end else begin
      dropped_d = dropped_q;
    end

    valid_d = cap_s;
    led_d   = {(mode_i == 2'd2), (dropped_d != 16'd0), freeze_i, led_q[0] ^ cap_s};
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= 2'd0;
      div_q     <= '0;
      ramp_q    <= '0;
      fc_q      <= '0;
      oreg_q    <= '0;
      valid_q   <= 1'b0;
      dropped_q <= 16'd0;
      led_q     <= 4'd0;
    end else begin
      mode_q    <= mode_i;
      div_q     <= div_d;
      ramp_q    <= ramp_d;
      fc_q      <= fc_d;
      oreg_q    <= oreg_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
      led_q     <= led_d;
    end
  end

  assign oreg_o    = oreg_q;
  assign valid_o   = valid_q;
  assign dropped_o = dropped_q;
  assign led_o     = led_q;

endmodule

// File: tb/tb_readout_framer.sv
// Bench for readout_framer: two instances (default and small test-pattern config) checked every
// cycle against a frame-level model, plus directed scenarios with hand-computed expectations.
module tb_readout_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode_i;
  logic        raw_tick, filt_tick, li_tick, freeze, clear;
  logic [47:0] raw_a, filt_a, li_a;
  logic [11:0] raw_b, filt_b, li_b;
  logic [63:0] oreg_a;
  logic [35:0] oreg_b;
  logic        valid_a, valid_b;
  logic [15:0] drop_a, drop_b;
  logic [3:0]  led_a, led_b;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  readout_framer #(.NCH(2), .DW(24), .CW(8), .TP_DIV(1000)) dut_a (
    .clk(clk), .reset(reset), .mode_i(mode_i),
    .raw_data_i(raw_a), .raw_tick_i(raw_tick),
    .filt_data_i(filt_a), .filt_tick_i(filt_tick),
    .li_data_i(li_a), .li_tick_i(li_tick),
    .freeze_i(freeze), .clear_i(clear),
    .oreg_o(oreg_a), .valid_o(valid_a), .dropped_o(drop_a), .led_o(led_a)
  );

  readout_framer #(.NCH(3), .DW(4), .CW(8), .TP_DIV(4)) dut_b (
    .clk(clk), .reset(reset), .mode_i(mode_i),
    .raw_data_i(raw_b), .raw_tick_i(raw_tick),
    .filt_data_i(filt_b), .filt_tick_i(filt_tick),
    .li_data_i(li_b), .li_tick_i(li_tick),
    .freeze_i(freeze), .clear_i(clear),
    .oreg_o(oreg_b), .valid_o(valid_b), .dropped_o(drop_b), .led_o(led_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // ---------------- behavioural model (one frame-level state per instance) ----------------
  int p_nch[2] = '{2, 3};
  int p_dw[2]  = '{24, 4};
  int p_tp[2]  = '{1000, 4};
  int m_mode[2], m_fc[2], m_drop[2], m_ramp[2], m_cnt[2];
  int m_led0[2], m_led1[2], m_valid[2], m_ofc[2];
  int m_smp[2][3];
  bit mdl_init = 1'b0;

  function automatic int in_data(int n, int src, int k);
    if (n == 0) begin
      case (src)
        0: return int'(raw_a[k*24 +: 24]);
        1: return int'(filt_a[k*24 +: 24]);
        default: return int'(li_a[k*24 +: 24]);
      endcase
    end else begin
      case (src)
        0: return int'(raw_b[k*4 +: 4]);
        1: return int'(filt_b[k*4 +: 4]);
        default: return int'(li_b[k*4 +: 4]);
      endcase
    end
  endfunction

  function automatic logic [63:0] exp_oreg(int n);
    logic [63:0] e = 64'd0;
    int fw = 8 + p_dw[n];
    for (int k = 0; k < p_nch[n]; k++)
      e = e | (((64'(m_ofc[n]) << p_dw[n]) | 64'(m_smp[n][k])) << (k * fw));
    return e;
  endfunction

  // Advance the model by one clock using the inputs the next rising edge will see.
  task automatic model_step(int n);
    int mask = (1 << p_dw[n]) - 1;
    bit sw, tick, act, dtick;
    if (reset) begin
      m_mode[n] = 0; m_fc[n] = 0; m_drop[n] = 0; m_ramp[n] = 0; m_cnt[n] = 0;
      m_led0[n] = 0; m_led1[n] = 0; m_valid[n] = 0; m_ofc[n] = 0;
      for (int k = 0; k < 3; k++) m_smp[n][k] = 0;
      return;
    end
    sw = (int'(mode_i) != m_mode[n]);
    case (m_mode[n])
      0: tick = raw_tick;
      1: tick = filt_tick;
      2: tick = li_tick;
      default: tick = (m_cnt[n] > 0) && (m_cnt[n] % p_tp[n] == 0);
    endcase
    act   = tick && !sw;
    dtick = act && freeze;
    m_valid[n] = act && !freeze;
    if (sw) m_fc[n] = 0;
    else if (act) m_fc[n] = (m_fc[n] + 1) % 256;
    if (act && m_mode[n] == 3) m_ramp[n] = (m_ramp[n] + 1) & mask;
    if (m_valid[n]) begin
      m_ofc[n] = m_fc[n];
      for (int k = 0; k < p_nch[n]; k++)
        m_smp[n][k] = (m_mode[n] == 3) ? ((m_ramp[n] + k) & mask) : in_data(n, m_mode[n], k);
    end
    if (clear) m_drop[n] = dtick ? 1 : 0;
    else if (dtick && m_drop[n] < 65535) m_drop[n]++;
    m_led0[n] ^= int'(m_valid[n]);
    m_led1[n] = int'(freeze);
    m_cnt[n]  = sw ? 1 : m_cnt[n] + 1;
    m_mode[n] = int'(mode_i);
  endtask

  // Compare process: check last edge's outputs, then step the model for the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mdl_init) begin
        for (int n = 0; n < 2; n++) begin
          logic [3:0] el;
          el = {m_mode[n] == 2, m_drop[n] != 0, m_led1[n][0], m_led0[n][0]};
          chk(n == 0 ? "A valid" : "B valid", n == 0 ? 64'(valid_a) : 64'(valid_b), 64'(m_valid[n]));
          chk(n == 0 ? "A oreg" : "B oreg", n == 0 ? oreg_a : 64'(oreg_b), exp_oreg(n));
          chk(n == 0 ? "A dropped" : "B dropped", n == 0 ? 64'(drop_a) : 64'(drop_b), 64'(m_drop[n]));
          chk(n == 0 ? "A led" : "B led", n == 0 ? 64'(led_a) : 64'(led_b), 64'(el));
        end
      end
      model_step(0);
      model_step(1);
      if (reset) mdl_init = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0] prev;
  logic [35:0] eb;

  initial begin
    reset = 1'b1; mode_i = 2'd0; raw_tick = 1'b0; filt_tick = 1'b0; li_tick = 1'b0;
    freeze = 1'b0; clear = 1'b0;
    raw_a = 48'd0; filt_a = 48'd0; li_a = 48'd0; raw_b = 12'd0; filt_b = 12'd0; li_b = 12'd0;
    repeat (3) cyc();
    chk("reset oreg", oreg_a, 64'd0);
    chk("reset valid", 64'(valid_a), 64'd0);
    reset = 1'b0;

    // Single lock-in frame with signed boundary sample.
    mode_i = 2'd2; cyc();
    li_tick = 1'b1; li_a = {24'h000005, 24'h800001}; li_b = 12'h321; cyc();
    li_tick = 1'b0;
    chk("li1 valid", 64'(valid_a), 64'd1);
    chk("li1 oreg", oreg_a, {8'h01, 24'h000005, 8'h01, 24'h800001});
    chk("li1 led", 64'(led_a), 64'b1001);
    cyc();
    chk("li1 pulse", 64'(valid_a), 64'd0);

    // Frame-counter wrap.
    for (int i = 2; i <= 257; i++) begin
      li_tick = 1'b1; li_a = {$urandom, $urandom}; li_b = 12'($urandom); cyc();
      li_tick = 1'b0;
      if (i == 256) chk("wrap fc00", 64'({oreg_a[63:56], oreg_a[31:24]}), 64'h0000);
      if (i == 257) chk("wrap fc01", 64'({oreg_a[63:56], oreg_a[31:24]}), 64'h0101);
      cyc();
    end

    // Freeze across three ticks.
    prev = oreg_a;
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      li_tick = 1'b1; li_a = {$urandom, $urandom}; cyc();
      li_tick = 1'b0;
      chk("frz valid", 64'(valid_a), 64'd0);
      chk("frz oreg", oreg_a, prev);
      cyc();
    end
    chk("frz dropped", 64'(drop_a), 64'd3);
    chk("frz led", 64'(led_a[2:1]), 64'b11);
    freeze = 1'b0; cyc();
    li_tick = 1'b1; li_a = {$urandom, $urandom}; cyc();
    li_tick = 1'b0;
    chk("unfrz valid", 64'(valid_a), 64'd1);
    chk("unfrz fc", 64'(oreg_a[63:56]), 64'h05);
    clear = 1'b1; cyc();
    clear = 1'b0;
    chk("clear dropped", 64'(drop_a), 64'd0);

    // Mode switch 2->0 coincident with a lock-in tick.
    prev = oreg_a;
    mode_i = 2'd0; li_tick = 1'b1; cyc();
    li_tick = 1'b0;
    chk("sw valid", 64'(valid_a), 64'd0);
    chk("sw oreg", oreg_a, prev);
    raw_tick = 1'b1; raw_a = {$urandom, $urandom}; cyc();
    raw_tick = 1'b0;
    chk("raw oreg", oreg_a, {8'h01, raw_a[47:24], 8'h01, raw_a[23:0]});
    li_tick = 1'b1; cyc();
    li_tick = 1'b0;
    chk("li ignored", 64'(valid_a), 64'd0);

    // Test pattern on the small instance, ramp wraps at 16.
    reset = 1'b1; cyc();
    reset = 1'b0; mode_i = 2'd3; cyc();
    for (int j = 1; j <= 15; j++) begin
      repeat (3) begin
        cyc();
        chk("tp idle", 64'(valid_b), 64'd0);
      end
      cyc();
      eb = {8'(j), 4'((j + 2) % 16), 8'(j), 4'((j + 1) % 16), 8'(j), 4'(j)};
      chk("tp valid", 64'(valid_b), 64'd1);
      chk("tp oreg", 64'(oreg_b), 64'(eb));
      if (j == 15) chk("tp wrap", 64'(oreg_b), 64'h0F10F00FF);
    end

    // Reset coincident with a tick mid-stream.
    mode_i = 2'd2; cyc();
    li_tick = 1'b1; li_a = {$urandom, $urandom}; cyc();
    freeze = 1'b1; cyc();
    li_tick = 1'b0; freeze = 1'b0; cyc();
    chk("pre-rst dropped", 64'(drop_a), 64'd1);
    li_tick = 1'b1; reset = 1'b1; cyc();
    li_tick = 1'b0; reset = 1'b0;
    chk("rst valid", 64'(valid_a), 64'd0);
    chk("rst oreg", oreg_a, 64'd0);
    chk("rst dropped", 64'(drop_a), 64'd0);
    chk("rst led", 64'(led_a), 64'd0);
    chk("rst oreg B", 64'(oreg_b), 64'd0);
    cyc();
    chk("post-rst valid", 64'(valid_a), 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39) == 0) mode_i = 2'($urandom);
      raw_tick  = ($urandom_range(3) == 0);
      filt_tick = ($urandom_range(3) == 0);
      li_tick   = ($urandom_range(3) == 0);
      raw_a  = {$urandom, $urandom}; filt_a = {$urandom, $urandom}; li_a = {$urandom, $urandom};
      raw_b  = 12'($urandom); filt_b = 12'($urandom); li_b = 12'($urandom);
      if ($urandom_range(15) == 0) freeze = ~freeze;
      clear = ($urandom_range(19) == 0);
      reset = ($urandom_range(399) == 0);
      cyc();
    end
    reset = 1'b0; raw_tick = 1'b0; filt_tick = 1'b0; li_tick = 1'b0; clear = 1'b0;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
